// File: rtl/div_sequencer_if.sv
// Handshake bundle between the execute stage and the divide sequencer.
// master = execute stage (request side), slave = div_sequencer.
interface div_sequencer_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic               signed_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;
   logic               stall_req_o;

   modport master (
      output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      input  result_o, ready_o, stall_req_o
   );

   modport slave (
      input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
      output result_o, ready_o, stall_req_o
   );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU sequencer; result is {HI,LO} = {rem, quot}.
// Ports: clk, rst (sync, active-high), div (slave side of div_sequencer_if).
module div_sequencer #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   div_sequencer_if.slave div
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVZERO,
      S_BUSY,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quot_q, quot_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               ready_q, ready_d;

   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   rem_nx, quot_nx;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               neg_a, neg_b, abort;

   assign neg_a = div.signed_i & div.opdata1_i[WIDTH-1];
   assign neg_b = div.signed_i & div.opdata2_i[WIDTH-1];
   assign abs_a = neg_a ? -div.opdata1_i : div.opdata1_i;
   assign abs_b = neg_b ? -div.opdata2_i : div.opdata2_i;
   assign abort = div.annul_i | ~div.start_i;

   // The shifted remainder can reach WIDTH+1 bits, so the trial
   // subtract is done one bit wider; its MSB is the borrow.
   assign trial   = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};
   assign rem_nx  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]}
                                 : trial[WIDTH-1:0];
   assign quot_nx = {quot_q[WIDTH-2:0], ~trial[WIDTH]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quot_d   = quot_q;
      dvsr_d   = dvsr_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      result_d = result_q;
      ready_d  = ready_q;
      unique case (state_q)
         S_IDLE: begin
            if (div.start_i && !div.annul_i) begin
               quot_d  = abs_a;
               dvsr_d  = abs_b;
               rem_d   = '0;
               cnt_d   = '0;
               negq_d  = neg_a ^ neg_b;
               negr_d  = neg_a;
               state_d = (abs_b == '0) ? S_DIVZERO : S_BUSY;
            end
         end
         S_DIVZERO: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               state_d  = S_DONE;
               result_d = '0;
               ready_d  = 1'b1;
            end
         end
         S_BUSY: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               rem_d  = rem_nx;
               quot_d = quot_nx;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d  = S_DONE;
                  ready_d  = 1'b1;
                  result_d = {negr_q ? -rem_nx : rem_nx,
                              negq_q ? -quot_nx : quot_nx};
               end
            end
         end
         S_DONE: begin
            if (abort) begin
               state_d  = S_IDLE;
               ready_d  = 1'b0;
               result_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quot_q   <= '0;
         dvsr_q   <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quot_q   <= quot_d;
         dvsr_q   <= dvsr_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign div.result_o    = result_q;
   assign div.ready_o     = ready_q;
   assign div.stall_req_o = div.start_i & ~ready_q & ~div.annul_i;
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer against an arithmetic model.
module tb_div_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   div_sequencer_if #(.WIDTH(32)) bus ();

   div_sequencer #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .div (bus)
   );

   function automatic logic [63:0] model(input logic s,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, sq, sr;
      logic [31:0] uq, ur;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
         sq = sa / sb;
         sr = sa % sb;
         return {sr[31:0], sq[31:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   // Starts a divide at the current negedge and waits for ready_o.
   // Operands are scrambled after the accept edge.
   task automatic run_div(input logic s, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] res,
                          output int lat, output int stalls);
      bus.start_i   = 1'b1;
      bus.signed_i  = s;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      #1;
      lat = -1;
      stalls = 0;
      res = '0;
      for (int c = 0; c < 100; c++) begin
         if (c > 0) @(negedge clk);
         if (c == 1) begin
            bus.signed_i  = ~s;
            bus.opdata1_i = $urandom;
            bus.opdata2_i = $urandom;
         end
         if (bus.ready_o) begin
            lat = c;
            res = bus.result_o;
            break;
         end
         if (bus.stall_req_o) stalls++;
      end
   endtask

   task automatic drop_start();
      bus.start_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.annul_i = 1'b0;
      bus.signed_i = 1'b0;
      bus.opdata1_i = '0;
      bus.opdata2_i = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 ||
          bus.stall_req_o !== 1'b0) begin
         failures++;
         $display("FAIL reset: ready=%b result=%h stall=%b want 0/0/0",
                  bus.ready_o, bus.result_o, bus.stall_req_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned();
      logic [63:0] r;
      int lat, st;
      run_div(1'b0, 32'd100, 32'd7, r, lat, st);
      checks++;
      if (r !== {32'd2, 32'd14}) begin
         failures++;
         $display("FAIL divu_result: got %h want %h", r, {32'd2, 32'd14});
      end
      checks++;
      if (lat !== 33) begin
         failures++;
         $display("FAIL divu_latency: got %0d want 33", lat);
      end
      checks++;
      if (st !== 33 || bus.stall_req_o !== 1'b0) begin
         failures++;
         $display("FAIL divu_stall: got %0d cycles (now %b) want 33 (0)",
                  st, bus.stall_req_o);
      end
      drop_start();
   endtask

   task automatic test_signed();
      logic [63:0] r;
      int lat, st;
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, r, lat, st);
      checks++;
      if (r !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
         failures++;
         $display("FAIL div_neg_pos: got %h want ffffffff_fffffffd", r);
      end
      drop_start();
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, r, lat, st);
      checks++;
      if (r !== {32'h00000001, 32'hFFFFFFFD}) begin
         failures++;
         $display("FAIL div_pos_neg: got %h want 00000001_fffffffd", r);
      end
      drop_start();
   endtask

   task automatic test_divzero();
      logic [63:0] r;
      int lat, st;
      run_div(1'b1, 32'd5, 32'd0, r, lat, st);
      checks++;
      if (lat !== 2 || r !== 64'd0) begin
         failures++;
         $display("FAIL divzero: lat=%0d result=%h want 2/0", lat, r);
      end
      drop_start();
      checks++;
      if (bus.ready_o !== 1'b0) begin
         failures++;
         $display("FAIL divzero_drop: ready=%b want 0", bus.ready_o);
      end
   endtask

   task automatic test_annul();
      int first = -1;
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'hFFFFFFFF;
      bus.opdata2_i = 32'd3;
      for (int c = 1; c <= 100 && first < 0; c++) begin
         @(negedge clk);
         bus.annul_i = (c == 10);
         #1;
         if (c == 10) begin
            checks++;
            if (bus.stall_req_o !== 1'b0) begin
               failures++;
               $display("FAIL annul_stall: got %b want 0", bus.stall_req_o);
            end
         end
         if (bus.ready_o) first = c;
      end
      // Restart is accepted in cycle 11, so ready lands 33 cycles later.
      checks++;
      if (first !== 44 || bus.result_o !== {32'd0, 32'h55555555}) begin
         failures++;
         $display("FAIL annul_restart: ready at %0d result %h want 44 %h",
                  first, bus.result_o, {32'd0, 32'h55555555});
      end
      @(negedge clk);
      drop_start();
   endtask

   task automatic test_overflow();
      logic [63:0] r;
      int lat, st;
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, r, lat, st);
      checks++;
      if (r !== {32'd0, 32'h80000000}) begin
         failures++;
         $display("FAIL overflow: got %h want 00000000_80000000", r);
      end
      drop_start();
      run_div(1'b0, 32'hFFFFFFFF, 32'd1, r, lat, st);
      checks++;
      if (r !== {32'd0, 32'hFFFFFFFF}) begin
         failures++;
         $display("FAIL max_unsigned: got %h want 00000000_ffffffff", r);
      end
      drop_start();
   endtask

   task automatic test_reset_mid();
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd9;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0 ||
          bus.stall_req_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: ready=%b result=%h stall=%b want 0/0/0",
                  bus.ready_o, bus.result_o, bus.stall_req_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hold();
      logic [63:0] r, exp;
      logic [31:0] a, b;
      int lat, st;
      a = $urandom;
      b = $urandom_range(1, 1000);
      exp = model(1'b0, a, b);
      run_div(1'b0, a, b, r, lat, st);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.ready_o !== 1'b1 || bus.result_o !== exp) begin
            failures++;
            $display("FAIL hold_%0d: ready=%b result=%h want 1 %h",
                     i, bus.ready_o, bus.result_o, exp);
         end
      end
      drop_start();
   endtask

   task automatic test_back_to_back();
      logic [63:0] r;
      int lat, st;
      run_div(1'b0, 32'd50, 32'd5, r, lat, st);
      drop_start();
      run_div(1'b1, 32'hFFFFFF9C, 32'd7, r, lat, st);
      checks++;
      if (lat !== 33 || r !== model(1'b1, 32'hFFFFFF9C, 32'd7)) begin
         failures++;
         $display("FAIL back_to_back: lat=%0d result=%h want 33 %h",
                  lat, r, model(1'b1, 32'hFFFFFF9C, 32'd7));
      end
      drop_start();
   endtask

   task automatic test_random();
      logic [63:0] r, exp;
      logic [31:0] a, b;
      logic s;
      int lat, st, sel;
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
         sel = $urandom_range(0, 7);
         b = (sel == 0) ? 32'd0 :
             (sel == 1) ? 32'($urandom_range(1, 15)) :
             (sel == 2) ? 32'hFFFFFFFF : $urandom;
         exp = model(s, a, b);
         run_div(s, a, b, r, lat, st);
         checks++;
         if (r !== exp || lat !== ((b == 0) ? 2 : 33)) begin
            failures++;
            $display("FAIL random_%0d: s=%b %h/%h got %h lat %0d want %h",
                     i, s, a, b, r, lat, exp);
         end
         drop_start();
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_divzero();
      test_annul();
      test_overflow();
      test_reset_mid();
      test_hold();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
